int8_dual_mac: RTL and testbench
================================

Name: int8_dual_mac

Overview:
- Parametrised successor to the packed dual INT8 multiplier: packs operands a and b into one wide multiplier word sharing operand c.
- Unpacks the a*c and b*c products with borrow correction, then accumulates both into two dot-product accumulators over a vector framed by in_last.
- Valid/ready input, held valid/ready output; sits between the operand streamer and the requantisation stage.

Parameters:
- DATA_W, 8, signed operand width (a, b, c); full range -2^(DATA_W-1)..2^(DATA_W-1)-1 legal.
- ACC_W, 32, signed accumulator width; must be >= 2*DATA_W.
- CNT_W, 16, beat-counter width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  operand beat valid
- in_ready  out  1  block can accept a beat
- in_last  in  1  final beat of the current vector
- a  in  DATA_W  signed operand A
- b  in  DATA_W  signed operand B
- c  in  DATA_W  signed shared operand C
- out_valid  out  1  result valid, held until accepted
- out_ready  in  1  downstream accepts result
- acc_ac  out  ACC_W  signed sum of a*c over vector
- acc_bc  out  ACC_W  signed sum of b*c over vector
- out_beats  out  CNT_W  beats in vector, saturating at all-ones
- out_ovf  out  1  sticky: any accumulation overflow in vector

Behaviour:
- Reset: in_ready=0 during rst, 1 the cycle after. out_valid=0, acc_ac=0, acc_bc=0, out_beats=0, out_ovf=0. All pipeline valids cleared. Accumulators cleared, first-beat flag set.
- stall = out_valid & ~out_ready. in_ready = ~stall & ~rst. Beat accepted when in_valid & in_ready. All stages advance only when ~stall.
- S1 (register): capture a, b, c, last, valid.
- S2 (multiply): SH = 2*DATA_W+2. P = ((a sign-extended << SH) + b sign-extended) * c, full signed width.
- S3 (unpack and accumulate):
  - pbc = P[SH-1:0] sign-truncated to 2*DATA_W.
  - pac = P[2*SH-1:SH] + P[SH-1] (borrow correction), truncated to 2*DATA_W.
  - Results must equal the exact a*c and b*c for all inputs, including -128*-128 = 16384.
- Accumulate:
  - If the first-beat flag is set: acc <= sign-extended product, beats <= 1, ovf <= 0.
  - Otherwise: acc <= acc + product, beats <= beats+1 saturating, ovf |= signed overflow of either add.
  - First-beat flag is set after a beat with last and cleared after any other beat.
- Result: a beat with last sets out_valid on the cycle it leaves S3. Latency is 3 clk edges from acceptance of the last beat to out_valid=1 when out_ready is held high.
- Outputs hold stable while out_valid & ~out_ready. out_valid drops the cycle after the handshake unless the next vector's last beat completes in that same cycle, in which case out_valid stays 1 with new data.
- Back-to-back vectors: a single-beat vector (in_last on every beat) yields one result per cycle with no bubbles when out_ready=1.
- Reset mid-vector discards the partial sums and any pending result. No output is produced for the discarded vector.
- in_valid=0 gaps: the pipeline drains normally and accumulators hold.

Optional Feature:
- Macro: INT8_DUAL_MAC_SAT_EN.
- Defined: each add saturates to [-2^(ACC_W-1), 2^(ACC_W-1)-1], and saturation sets out_ovf.
- Undefined: two's-complement wrap, with out_ovf still flagging the overflow.

Decomposition:
- Package int8_mac_pkg holds:
  - SH_F(DATA_W) shift function;
  - typedef prod_t (signed 2*DATA_W);
  - acc_sat() helper;
  - default width constants.
- One sub-module, int8_pack_mult, covers S1–S2 plus the unpack and correction logic with a registered output. It is reusable as the plain dual multiplier.

Test Plan:
- Single beat a=3, b=-5, c=7, last=1 -> after 3 edges acc_ac=21, acc_bc=-35, out_beats=1, out_ovf=0.
- Corners a=-128, b=127, c=-128 -> per-beat products 16384 and -16256. 4-beat vector gives acc_ac=65536, acc_bc=-65024, out_beats=4.
- Random 10k beats with random last, a/b/c full range, compared against a reference model -> zero mismatches.
- Hold out_ready=0 for 5 cycles with a result pending -> in_ready=0, outputs stable, nothing lost after release.
- ACC_W=16, 3 beats of 127*127 -> SAT_EN: acc_ac=32767, out_ovf=1. Without SAT_EN: acc_ac=-17149 (wrapped), out_ovf=1.
- Assert rst mid-vector after 2 beats, then send a 1-beat vector a=1, b=1, c=1 -> result 1/1, out_beats=1, no stale result.

Source files
------------

// File: rtl/int8_dual_mac_pkg.sv
// =============================================================================
// int8_mac_pkg : shared widths, packing shift and accumulator saturation helper
// Rev 1.0 - initial release
// =============================================================================
`default_nettype none

package int8_mac_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int ACC_W_DEF  = 32;
    localparam int CNT_W_DEF  = 16;
    localparam int SUM_W      = 64;

    typedef logic signed [2*DATA_W_DEF-1:0] prod_t;

    // Gap between the packed a and b lanes; two guard bits keep b*c clear of a*c.
    function automatic int SH_F(input int data_w);
        return 2*data_w + 2;
    endfunction

    // Clamp a wide sum into the signed range of an acc_w-bit accumulator (acc_w <= 63).
    function automatic logic signed [SUM_W-1:0] acc_sat(input logic signed [SUM_W-1:0] sum,
                                                        input int acc_w);
        logic signed [SUM_W-1:0] hi;
        logic signed [SUM_W-1:0] lo;
        hi = (64'sd1 <<< (acc_w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (acc_w - 1));
        if (sum > hi) begin
            return hi;
        end else if (sum < lo) begin
            return lo;
        end
        return sum;
    endfunction

endpackage

`default_nettype wire

// File: rtl/int8_pack_mult.sv
// =============================================================================
// int8_pack_mult : registered operands, one packed multiply, borrow-corrected unpack
// Rev 1.0 - initial release
// =============================================================================
`default_nettype none

module int8_pack_mult
    import int8_mac_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en_i,
    input  logic                       valid_i,
    input  logic                       last_i,
    input  logic signed [DATA_W-1:0]   a_i,
    input  logic signed [DATA_W-1:0]   b_i,
    input  logic signed [DATA_W-1:0]   c_i,
    output logic                       valid_o,
    output logic                       last_o,
    output logic signed [2*DATA_W-1:0] pac_o,
    output logic signed [2*DATA_W-1:0] pbc_o
);

    localparam int SH = SH_F(DATA_W);
    localparam int PW = 2*SH;

    logic                     s1_valid_q;
    logic                     s1_last_q;
    logic signed [DATA_W-1:0] s1_a_q;
    logic signed [DATA_W-1:0] s1_b_q;
    logic signed [DATA_W-1:0] s1_c_q;
    logic                     s2_valid_q;
    logic                     s2_last_q;
    logic signed [PW-1:0]     s2_p_q;

    logic signed [PW-1:0]     w_packed;
    logic signed [PW-1:0]     w_p;
    logic                     w_unused;

    always_comb begin
        w_packed = (PW'(s1_a_q) <<< SH) + PW'(s1_b_q);
        w_p      = w_packed * PW'(s1_c_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_last_q  <= 1'b0;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
            s1_c_q     <= '0;
            s2_valid_q <= 1'b0;
            s2_last_q  <= 1'b0;
            s2_p_q     <= '0;
        end else if (en_i) begin
            s1_valid_q <= valid_i;
            s1_last_q  <= last_i;
            s1_a_q     <= a_i;
            s1_b_q     <= b_i;
            s1_c_q     <= c_i;
            s2_valid_q <= s1_valid_q;
            s2_last_q  <= s1_last_q;
            s2_p_q     <= w_p;
        end
    end

    // A negative b*c borrows one from the upper lane; bit SH-1 is its sign.
    assign pbc_o   = s2_p_q[2*DATA_W-1:0];
    assign pac_o   = s2_p_q[SH +: 2*DATA_W] + {{(2*DATA_W-1){1'b0}}, s2_p_q[SH-1]};
    assign valid_o = s2_valid_q;
    assign last_o  = s2_last_q;

    assign w_unused = ^{s2_p_q[PW-1:SH+2*DATA_W], s2_p_q[SH-2:2*DATA_W]};

endmodule

`default_nettype wire

// File: rtl/int8_dual_mac.sv
// =============================================================================
// int8_dual_mac : packed dual multiply feeding two dot-product accumulators
// Optional build macro INT8_DUAL_MAC_SAT_EN selects saturating adds (else wrap).
// Rev 1.0 - initial release
// =============================================================================
`default_nettype none

module int8_dual_mac
    import int8_mac_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ACC_W  = ACC_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     in_last,
    input  logic signed [DATA_W-1:0] a,
    input  logic signed [DATA_W-1:0] b,
    input  logic signed [DATA_W-1:0] c,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [ACC_W-1:0]  acc_ac,
    output logic signed [ACC_W-1:0]  acc_bc,
    output logic [CNT_W-1:0]         out_beats,
    output logic                     out_ovf
);

    logic signed [ACC_W-1:0]    acc_ac_q, acc_ac_d;
    logic signed [ACC_W-1:0]    acc_bc_q, acc_bc_d;
    logic [CNT_W-1:0]           beats_q, beats_d;
    logic                       ovf_q, ovf_d;
    logic                       first_q, first_d;
    logic                       out_valid_q, out_valid_d;

    logic                       w_stall;
    logic                       w_s2_valid;
    logic                       w_s2_last;
    logic signed [2*DATA_W-1:0] w_pac;
    logic signed [2*DATA_W-1:0] w_pbc;
    logic signed [SUM_W-1:0]    w_sum_ac;
    logic signed [SUM_W-1:0]    w_sum_bc;
    logic                       w_ovf_ac;
    logic                       w_ovf_bc;

    assign w_stall  = out_valid_q & ~out_ready;
    assign in_ready = ~w_stall & ~rst;

    int8_pack_mult #(
        .DATA_W (DATA_W)
    ) u_pack_mult (
        .clk     (clk),
        .rst     (rst),
        .en_i    (~w_stall),
        .valid_i (in_valid & in_ready),
        .last_i  (in_last),
        .a_i     (a),
        .b_i     (b),
        .c_i     (c),
        .valid_o (w_s2_valid),
        .last_o  (w_s2_last),
        .pac_o   (w_pac),
        .pbc_o   (w_pbc)
    );

    always_comb begin
        acc_ac_d    = acc_ac_q;
        acc_bc_d    = acc_bc_q;
        beats_d     = beats_q;
        ovf_d       = ovf_q;
        first_d     = first_q;
        out_valid_d = out_valid_q;

        // The wide sum is exact, so any clamp by acc_sat marks an overflow.
        w_sum_ac = SUM_W'(acc_ac_q) + SUM_W'(w_pac);
        w_sum_bc = SUM_W'(acc_bc_q) + SUM_W'(w_pbc);
        w_ovf_ac = (acc_sat(w_sum_ac, ACC_W) != w_sum_ac);
        w_ovf_bc = (acc_sat(w_sum_bc, ACC_W) != w_sum_bc);

        if (!w_stall) begin
            out_valid_d = w_s2_valid & w_s2_last;
            if (w_s2_valid) begin
                first_d = w_s2_last;
                if (first_q) begin
                    acc_ac_d = ACC_W'(w_pac);
                    acc_bc_d = ACC_W'(w_pbc);
                    beats_d  = CNT_W'(1);
                    ovf_d    = 1'b0;
                end else begin
`ifdef INT8_DUAL_MAC_SAT_EN
                    acc_ac_d = ACC_W'(acc_sat(w_sum_ac, ACC_W));
                    acc_bc_d = ACC_W'(acc_sat(w_sum_bc, ACC_W));
`else
                    acc_ac_d = ACC_W'(w_sum_ac);
                    acc_bc_d = ACC_W'(w_sum_bc);
`endif
                    beats_d  = (beats_q == '1) ? beats_q : beats_q + CNT_W'(1);
                    ovf_d    = ovf_q | w_ovf_ac | w_ovf_bc;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_ac_q    <= '0;
            acc_bc_q    <= '0;
            beats_q     <= '0;
            ovf_q       <= 1'b0;
            first_q     <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            acc_ac_q    <= acc_ac_d;
            acc_bc_q    <= acc_bc_d;
            beats_q     <= beats_d;
            ovf_q       <= ovf_d;
            first_q     <= first_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_valid = out_valid_q;
    assign acc_ac    = acc_ac_q;
    assign acc_bc    = acc_bc_q;
    assign out_beats = beats_q;
    assign out_ovf   = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_int8_dual_mac.sv
// =============================================================================
// tb_int8_dual_mac : directed table, handshake corner sequences and random model check
// Rev 1.0 - initial release
// =============================================================================
`default_nettype none

module tb_int8_dual_mac;

    logic               clk = 1'b0;
    logic               rst;
    logic               in_valid;
    logic               in_ready;
    logic               in_last;
    logic signed [7:0]  a;
    logic signed [7:0]  b;
    logic signed [7:0]  c;
    logic               out_valid;
    logic               out_ready;
    logic signed [31:0] acc_ac;
    logic signed [31:0] acc_bc;
    logic [15:0]        out_beats;
    logic               out_ovf;

    logic               in_ready16;
    logic               out_valid16;
    logic signed [15:0] acc_ac16;
    logic signed [15:0] acc_bc16;
    logic [15:0]        out_beats16;
    logic               out_ovf16;

    always #5 clk = ~clk;

    int8_dual_mac dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
        .a(a), .b(b), .c(c), .out_valid(out_valid), .out_ready(out_ready),
        .acc_ac(acc_ac), .acc_bc(acc_bc), .out_beats(out_beats), .out_ovf(out_ovf)
    );

    int8_dual_mac #(.ACC_W(16)) dut16 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready16), .in_last(in_last),
        .a(a), .b(b), .c(c), .out_valid(out_valid16), .out_ready(out_ready),
        .acc_ac(acc_ac16), .acc_bc(acc_bc16), .out_beats(out_beats16), .out_ovf(out_ovf16)
    );

    typedef struct {
        int a; int b; int c; bit last;
        int exp_ac; int exp_bc; int exp_beats; bit exp_ovf;
    } vec_t;

    typedef struct {
        int ac; int bc; int beats; bit ovf;
    } res_t;

    int     checks = 0;
    int     errors = 0;
    int     results_seen = 0;
    bit     mon_en = 1'b0;
    bit     use_model = 1'b0;
    res_t   expq[$];
    vec_t   vecs[11];

    longint m_ac, m_bc;
    int     m_beats;
    bit     m_ovf, m_first;

    task automatic chk(input string name, input longint got, input longint want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, got, want);
        end
    endtask

    task automatic model_add(inout longint acc, input longint p, inout bit ovf);
        longint s;
        s = acc + p;
        if (s > 64'sd2147483647 || s < -64'sd2147483648) ovf = 1'b1;
`ifdef INT8_DUAL_MAC_SAT_EN
        if (s > 64'sd2147483647) s = 64'sd2147483647;
        if (s < -64'sd2147483648) s = -64'sd2147483648;
`else
        s = longint'(int'(s));
`endif
        acc = s;
    endtask

    task automatic model_beat(input int av, input int bv, input int cv, input bit lv);
        longint pac, pbc;
        res_t r;
        pac = longint'(av * cv);
        pbc = longint'(bv * cv);
        if (m_first) begin
            m_ac = pac; m_bc = pbc; m_beats = 1; m_ovf = 1'b0;
        end else begin
            model_add(m_ac, pac, m_ovf);
            model_add(m_bc, pbc, m_ovf);
            if (m_beats < 65535) m_beats++;
        end
        m_first = lv;
        if (lv) begin
            r = '{ac: int'(m_ac), bc: int'(m_bc), beats: m_beats, ovf: m_ovf};
            expq.push_back(r);
        end
    endtask

    task automatic push_exp(input int ac, input int bc, input int beats, input bit ovf);
        res_t r;
        r = '{ac: ac, bc: bc, beats: beats, ovf: ovf};
        expq.push_back(r);
    endtask

    // Returns 1 time unit after the accepting edge.
    task automatic send_beat(input int av, input int bv, input int cv, input bit lv,
                             input bit rnd_rdy);
        int n;
        bit ok;
        n  = 0;
        ok = 1'b0;
        while (!ok) begin
            @(negedge clk);
            in_valid = 1'b1;
            a        = av[7:0];
            b        = bv[7:0];
            c        = cv[7:0];
            in_last  = lv;
            if (rnd_rdy) out_ready = ($urandom_range(0, 3) != 0);
            #1;
            ok = in_ready;
            @(posedge clk);
            n++;
            if (!ok && n > 200) begin
                checks++;
                errors++;
                $display("FAIL send_timeout: beat not accepted after %0d cycles, required acceptance", n);
                ok = 1'b1;
            end
        end
        #1;
        if (use_model) model_beat(av, bv, cv, lv);
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n;
        @(negedge clk);
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        n = 0;
        while (expq.size() != 0 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain_pending", expq.size(), 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_in_ready16", in_ready16, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_acc_ac", acc_ac, 0);
        chk("rst_acc_bc", acc_bc, 0);
        chk("rst_beats", out_beats, 0);
        chk("rst_ovf", out_ovf, 0);
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", in_ready, 1);
        m_first = 1'b1;
        expq.delete();
    endtask

    always @(negedge clk) begin : mon
        res_t r;
        #1;
        if (mon_en && !rst && out_valid && out_ready) begin
            results_seen++;
            checks++;
            if (expq.size() == 0) begin
                errors++;
                $display("FAIL unexpected_result: got ac=%0d bc=%0d beats=%0d, required no result",
                         acc_ac, acc_bc, out_beats);
            end else begin
                r = expq.pop_front();
                if (acc_ac !== r.ac || acc_bc !== r.bc || out_beats !== 16'(r.beats) || out_ovf !== r.ovf) begin
                    errors++;
                    $display("FAIL result: got ac=%0d bc=%0d beats=%0d ovf=%0d, required ac=%0d bc=%0d beats=%0d ovf=%0d",
                             acc_ac, acc_bc, out_beats, out_ovf, r.ac, r.bc, r.beats, r.ovf);
                end
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation still running, required completion");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int seen0;
        int n;
        int av, bv, cv;
        bit lv;

        rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; c = '0;
        m_first = 1'b1; m_ac = 0; m_bc = 0; m_beats = 0; m_ovf = 1'b0;

        vecs[0]  = '{3, -5, 7, 1, 21, -35, 1, 0};
        vecs[1]  = '{-128, 127, -128, 0, 0, 0, 0, 0};
        vecs[2]  = '{-128, 127, -128, 0, 0, 0, 0, 0};
        vecs[3]  = '{-128, 127, -128, 0, 0, 0, 0, 0};
        vecs[4]  = '{-128, 127, -128, 1, 65536, -65024, 4, 0};
        vecs[5]  = '{-128, -128, -128, 1, 16384, 16384, 1, 0};
        vecs[6]  = '{127, -128, 127, 1, 16129, -16256, 1, 0};
        vecs[7]  = '{0, 5, -9, 1, 0, -45, 1, 0};
        vecs[8]  = '{2, 3, 4, 0, 0, 0, 0, 0};
        vecs[9]  = '{-1, -1, -1, 1, 9, 13, 2, 0};
        vecs[10] = '{-128, 127, 127, 1, -16256, 16129, 1, 0};

        do_reset();

        // Latency of a single-beat vector and out_valid drop after the handshake
        send_beat(3, -5, 7, 1, 0);
        in_valid = 1'b0;
        @(posedge clk); #1;
        chk("lat_edge2_valid", out_valid, 0);
        @(posedge clk); #1;
        chk("lat_edge3_valid", out_valid, 1);
        chk("lat_acc_ac", acc_ac, 21);
        chk("lat_acc_bc", acc_bc, -35);
        chk("lat_beats", out_beats, 1);
        chk("lat_ovf", out_ovf, 0);
        @(posedge clk); #1;
        chk("valid_drop", out_valid, 0);

        // Directed table
        mon_en = 1'b1;
        foreach (vecs[i]) begin
            send_beat(vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].last, 0);
            if (vecs[i].last) push_exp(vecs[i].exp_ac, vecs[i].exp_bc, vecs[i].exp_beats, vecs[i].exp_ovf);
        end
        drain();

        // Back-to-back single-beat vectors: one result per cycle
        for (int i = 0; i < 4; i++) begin
            send_beat(i + 1, -(i + 1), 3, 1, 0);
            push_exp(3 * (i + 1), -3 * (i + 1), 1, 0);
        end
        in_valid = 1'b0;
        chk("b2b_valid0", out_valid, 1);
        @(posedge clk); #1;
        chk("b2b_valid1", out_valid, 1);
        @(posedge clk); #1;
        chk("b2b_valid2", out_valid, 1);
        @(posedge clk); #1;
        chk("b2b_valid_end", out_valid, 0);
        drain();

        // Backpressure: result held for 5 cycles, nothing lost afterwards
        out_ready = 1'b0;
        push_exp(3, 6, 1, 0);
        push_exp(-24, 30, 1, 0);
        push_exp(-63, 72, 1, 0);
        push_exp(-120, -132, 1, 0);
        send_beat(1, 2, 3, 1, 0);
        send_beat(-4, 5, 6, 1, 0);
        send_beat(7, -8, -9, 1, 0);
        a = 8'sd10; b = 8'sd11; c = -8'sd12; in_last = 1'b1; in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            chk("stall_in_ready", in_ready, 0);
            chk("stall_out_valid", out_valid, 1);
            chk("stall_acc_ac", acc_ac, 3);
            chk("stall_acc_bc", acc_bc, 6);
        end
        out_ready = 1'b1;
        send_beat(10, 11, -12, 1, 0);
        drain();

        // ACC_W=16 instance: 3 x 127*127 overflows the narrow accumulator
        do_reset();
        push_exp(48387, 0, 3, 0);
        send_beat(127, 0, 127, 0, 0);
        send_beat(127, 0, 127, 0, 0);
        send_beat(127, 0, 127, 1, 0);
        in_valid = 1'b0;
        n = 0;
        while (!out_valid16 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("acc16_valid", out_valid16, 1);
`ifdef INT8_DUAL_MAC_SAT_EN
        chk("acc16_acc_ac", acc_ac16, 32767);
`else
        chk("acc16_acc_ac", acc_ac16, -17149);
`endif
        chk("acc16_acc_bc", acc_bc16, 0);
        chk("acc16_beats", out_beats16, 3);
        chk("acc16_ovf", out_ovf16, 1);
        drain();

        // Reset mid-vector discards the partial sums
        send_beat(5, 5, 5, 0, 0);
        send_beat(5, 5, 5, 0, 0);
        in_valid = 1'b0;
        do_reset();
        seen0 = results_seen;
        push_exp(1, 1, 1, 0);
        send_beat(1, 1, 1, 1, 0);
        drain();
        repeat (4) idle_cycle();
        chk("rst_mid_results", results_seen - seen0, 1);

        // Random beats against the reference model with random backpressure and gaps
        use_model = 1'b1;
        for (int i = 0; i < 10000; i++) begin
            av = int'($urandom_range(0, 255)) - 128;
            bv = int'($urandom_range(0, 255)) - 128;
            cv = int'($urandom_range(0, 255)) - 128;
            lv = ($urandom_range(0, 7) == 0) || (i == 9999);
            send_beat(av, bv, cv, lv, 1);
            if ($urandom_range(0, 15) == 0) idle_cycle();
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
